// File: rtl/tt_pad_rx.sv
// Receive side of a shared bidirectional line: synchronise, blank while driving/turnaround, deglitch.
// Latency: SYNC_STAGES+FILT_CYC clk edges from a stable pad change to z_o / strobe, once in RECV.
// Backpressure: none; free-running sampler, all outputs registered and valid every cycle.
module tt_pad_rx #(
    parameter int   SYNC_STAGES = 2,
    parameter int   TURN_CYC    = 2,
    parameter int   FILT_CYC    = 3,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    input  logic drv_en_n,
    output logic z_o,
    output logic rise_o,
    output logic fall_o,
    output logic rx_valid_o
);

    localparam int MAX_CNT = (TURN_CYC > FILT_CYC) ? TURN_CYC : FILT_CYC;
    localparam int CW      = $clog2(MAX_CNT + 1);

    // The turnaround count and the filter count are never live at the same
    // time (TURN vs RECV), so a single counter serves both.
    localparam logic [CW-1:0] TURN_LAST = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYC - 1);

    typedef enum logic [1:0] {
        DRIVE = 2'd0,
        TURN  = 2'd1,
        RECV  = 2'd2
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // Metastability chain on the asynchronous pad; keeps running in every state
    // so the sampled value is already settled when blanking ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad_i};
        end
    end

    // Ownership FSM plus deglitch filter; local drive pre-empts everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DRIVE;
            cnt        <= '0;
            z_o        <= RST_VAL;
            rise_o     <= 1'b0;
            fall_o     <= 1'b0;
            rx_valid_o <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (!drv_en_n) begin
                // Our own driver owns the line: hold z_o, drop any partial filter.
                state      <= DRIVE;
                cnt        <= '0;
                rx_valid_o <= 1'b0;
            end else begin
                case (state)
                    DRIVE: begin
                        cnt <= '0;
                        if (TURN_CYC == 0) begin
                            state      <= RECV;
                            rx_valid_o <= 1'b1;
                        end else begin
                            state <= TURN;
                        end
                    end
                    TURN: begin
                        // Line may still carry our own tail or the bus-keeper; ignore s.
                        if (cnt == TURN_LAST) begin
                            state      <= RECV;
                            cnt        <= '0;
                            rx_valid_o <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RECV: begin
                        if (s != z_o) begin
                            if (cnt == FILT_LAST) begin
                                z_o    <= s;
                                cnt    <= '0;
                                rise_o <= s;
                                fall_o <= ~s;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            // Level came back before persisting: glitch rejected.
                            cnt <= '0;
                        end
                    end
                    default: begin
                        state      <= DRIVE;
                        cnt        <= '0;
                        rx_valid_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
